// File: rtl/sync_pkg.sv
// Shared definitions for the data_sync_ctrl slice.
//   state_t     : handshake FSM state encoding
//   XFER_CNT_W  : width of the completed-transfer counter
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        ACK_HI   = 2'd2
    } state_t;

    localparam int unsigned XFER_CNT_W = 8;

endpackage

// File: rtl/req_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
//   CLK      : destination clock
//   RST      : asynchronous active-high reset, clears every stage
//   async_in : bit from the foreign clock domain
//   sync_out : last stage, safe to use in the CLK domain
module req_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] stage_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// Four-phase request/acknowledge receiver that moves a data word from a foreign
// clock domain into the CLK domain. Only the request is synchronized; the bus is
// captured directly because the source holds it stable while UNSYNC_REQ is high.
//   CLK, RST    : destination clock, asynchronous active-high reset
//   UNSYNC_REQ  : request from the source domain
//   UNSYNC_BUS  : source data word
//   SYNC_READY  : local consumer can take a word this cycle
//   SYNC_ACK    : acknowledge back to the source (high only in ACK_HI)
//   SYNC_BUS    : captured word, held until the next capture
//   SYNC_VALID  : one-cycle pulse when SYNC_BUS is updated
//   BUSY        : FSM not idle
//   PROTO_ERR   : sticky, request withdrawn before it was captured
//   XFER_CNT    : completed transfers, wraps at 255
module data_sync_ctrl
    import sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  UNSYNC_REQ,
    input  logic [BUS_WIDTH-1:0]  UNSYNC_BUS,
    input  logic                  SYNC_READY,
    output logic                  SYNC_ACK,
    output logic [BUS_WIDTH-1:0]  SYNC_BUS,
    output logic                  SYNC_VALID,
    output logic                  BUSY,
    output logic                  PROTO_ERR,
    output logic [XFER_CNT_W-1:0] XFER_CNT
);

    logic req_s;

    req_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (UNSYNC_REQ),
        .sync_out (req_s)
    );

    state_t                  state_q, state_d;
    logic                    capture;
    logic                    set_err;
    logic                    inc_cnt;
    logic [BUS_WIDTH-1:0]    bus_q;
    logic                    valid_q;
    logic                    err_q;
    logic [XFER_CNT_W-1:0]   cnt_q;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        set_err = 1'b0;
        inc_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (SYNC_READY) begin
                        capture = 1'b1;
                        state_d = ACK_HI;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                // A withdrawn request takes priority over a late READY.
                if (!req_s) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else if (SYNC_READY) begin
                    capture = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    inc_cnt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            bus_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= capture;
            if (capture) begin
                bus_q <= UNSYNC_BUS;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (inc_cnt) begin
                cnt_q <= cnt_q + XFER_CNT_W'(1);
            end
        end
    end

    assign SYNC_ACK   = (state_q == ACK_HI);
    assign BUSY       = (state_q != IDLE);
    assign SYNC_BUS   = bus_q;
    assign SYNC_VALID = valid_q;
    assign PROTO_ERR  = err_q;
    assign XFER_CNT   = cnt_q;

endmodule

// File: tb/tb_data_sync_ctrl.sv
module tb_data_sync_ctrl;

    localparam int N  = 2;
    localparam int N3 = 3;

    logic        CLK;
    logic        RST;

    // Main instance: NUM_STAGES=2, BUS_WIDTH=8
    logic        UNSYNC_REQ;
    logic [7:0]  UNSYNC_BUS;
    logic        SYNC_READY;
    logic        SYNC_ACK;
    logic [7:0]  SYNC_BUS;
    logic        SYNC_VALID;
    logic        BUSY;
    logic        PROTO_ERR;
    logic [7:0]  XFER_CNT;

    // Second instance: NUM_STAGES=3, BUS_WIDTH=16
    logic        req3;
    logic [15:0] bus3;
    logic        ready3;
    logic        ack3;
    logic [15:0] sbus3;
    logic        valid3;
    logic        busy3;
    logic        err3;
    logic [7:0]  cnt3;

    data_sync_ctrl #(
        .NUM_STAGES(N),
        .BUS_WIDTH (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .UNSYNC_REQ(UNSYNC_REQ),
        .UNSYNC_BUS(UNSYNC_BUS),
        .SYNC_READY(SYNC_READY),
        .SYNC_ACK  (SYNC_ACK),
        .SYNC_BUS  (SYNC_BUS),
        .SYNC_VALID(SYNC_VALID),
        .BUSY      (BUSY),
        .PROTO_ERR (PROTO_ERR),
        .XFER_CNT  (XFER_CNT)
    );

    data_sync_ctrl #(
        .NUM_STAGES(N3),
        .BUS_WIDTH (16)
    ) dut3 (
        .CLK       (CLK),
        .RST       (RST),
        .UNSYNC_REQ(req3),
        .UNSYNC_BUS(bus3),
        .SYNC_READY(ready3),
        .SYNC_ACK  (ack3),
        .SYNC_BUS  (sbus3),
        .SYNC_VALID(valid3),
        .BUSY      (busy3),
        .PROTO_ERR (err3),
        .XFER_CNT  (cnt3)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected words in capture order, transfer count, error flag.
    logic [7:0] sb_q[$];
    int         exp_cnt    = 0;
    bit         exp_err    = 1'b0;
    int         exp_pulses = 0;
    int         seen_pulses = 0;
    int         seen_pulses3 = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Scoreboard monitor: every SYNC_VALID pulse must match the oldest expected word.
    always @(negedge CLK) begin
        if (SYNC_VALID) begin
            seen_pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got bus %0h, expected no pulse at %0t",
                         SYNC_BUS, $time);
            end else begin
                check("sb_data", 32'(SYNC_BUS), 32'(sb_q.pop_front()));
            end
        end
        if (valid3) seen_pulses3++;
    end

    // One complete four-phase transfer, starting and ending on a falling edge.
    task automatic xfer(input logic [7:0] data, input int rdy_delay, input bit detailed);
        UNSYNC_BUS = data;
        UNSYNC_REQ = 1'b1;
        SYNC_READY = (rdy_delay == 0);
        sb_q.push_back(data);
        exp_pulses++;
        if (rdy_delay == 0) begin
            tick(N);
            if (detailed) begin
                check("lat_early_valid", 32'(SYNC_VALID), 32'd0);
                check("lat_early_ack", 32'(SYNC_ACK), 32'd0);
            end
            tick(1);
            check("lat_valid", 32'(SYNC_VALID), 32'd1);
            check("lat_ack", 32'(SYNC_ACK), 32'd1);
        end else begin
            tick(N + 1);
            check("wait_busy", 32'(BUSY), 32'd1);
            check("wait_no_ack", 32'(SYNC_ACK), 32'd0);
            check("wait_no_valid", 32'(SYNC_VALID), 32'd0);
            for (int i = 1; i < rdy_delay; i++) begin
                tick(1);
                check("wait_hold", 32'(SYNC_VALID | SYNC_ACK), 32'd0);
            end
            SYNC_READY = 1'b1;
            tick(1);
            check("rdy_valid", 32'(SYNC_VALID), 32'd1);
            check("rdy_ack", 32'(SYNC_ACK), 32'd1);
        end
        tick(1);
        check("valid_one_cycle", 32'(SYNC_VALID), 32'd0);
        UNSYNC_REQ = 1'b0;
        tick(N);
        if (detailed) check("ack_hold", 32'(SYNC_ACK), 32'd1);
        tick(1);
        exp_cnt = (exp_cnt + 1) % 256;
        check("ack_fall", 32'(SYNC_ACK), 32'd0);
        check("busy_idle", 32'(BUSY), 32'd0);
        check("xfer_cnt", 32'(XFER_CNT), 32'(exp_cnt));
        check("proto_err", 32'(PROTO_ERR), 32'(exp_err));
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        UNSYNC_REQ = 1'b0;
        UNSYNC_BUS = '0;
        SYNC_READY = 1'b0;
        req3       = 1'b0;
        bus3       = '0;
        ready3     = 1'b1;
        tick(3);

        // Reset values
        check("rst_ack", 32'(SYNC_ACK), 32'd0);
        check("rst_bus", 32'(SYNC_BUS), 32'd0);
        check("rst_valid", 32'(SYNC_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(PROTO_ERR), 32'd0);
        check("rst_cnt", 32'(XFER_CNT), 32'd0);
        RST = 1'b0;
        tick(2);

        // Basic transfer and ready-stall transfer
        xfer(8'hA5, 0, 1'b1);
        check("hold_bus_a5", 32'(SYNC_BUS), 32'hA5);
        xfer(8'h3C, 5, 1'b1);

        // Request withdrawn while waiting for READY
        UNSYNC_BUS = 8'h77;
        UNSYNC_REQ = 1'b1;
        SYNC_READY = 1'b0;
        tick(N + 1);
        check("perr_wait_busy", 32'(BUSY), 32'd1);
        UNSYNC_REQ = 1'b0;
        tick(N);
        check("perr_still_busy", 32'(BUSY), 32'd1);
        tick(1);
        exp_err = 1'b1;
        check("perr_set", 32'(PROTO_ERR), 32'd1);
        check("perr_idle", 32'(BUSY), 32'd0);
        check("perr_bus_kept", 32'(SYNC_BUS), 32'h3C);
        tick(2);
        xfer(8'h42, 0, 1'b1);

        // Asynchronous reset while in ACK_HI, request held high through release
        UNSYNC_BUS = 8'h5A;
        UNSYNC_REQ = 1'b1;
        SYNC_READY = 1'b1;
        sb_q.push_back(8'h5A);
        exp_pulses++;
        tick(N + 1);
        check("pre_rst_ack", 32'(SYNC_ACK), 32'd1);
        #1 RST = 1'b1;
        #1;
        check("async_rst_ack", 32'(SYNC_ACK), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_err", 32'(PROTO_ERR), 32'd0);
        check("async_rst_cnt", 32'(XFER_CNT), 32'd0);
        exp_cnt = 0;
        exp_err = 1'b0;
        tick(1);
        RST = 1'b0;
        sb_q.push_back(8'h5A);
        exp_pulses++;
        tick(N);
        check("relaunch_early", 32'(SYNC_VALID), 32'd0);
        tick(1);
        check("relaunch_valid", 32'(SYNC_VALID), 32'd1);
        check("relaunch_ack", 32'(SYNC_ACK), 32'd1);
        UNSYNC_REQ = 1'b0;
        tick(N + 1);
        exp_cnt = 1;
        check("relaunch_cnt", 32'(XFER_CNT), 32'(exp_cnt));

        // 256 back-to-back transfers from a cleared counter
        pulse_reset();
        for (int i = 0; i < 256; i++) xfer(8'(i), 0, 1'b0);
        check("cnt_wrap", 32'(XFER_CNT), 32'd0);

        // Randomized data and READY stalls
        for (int i = 0; i < 24; i++) begin
            xfer(8'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        // Deeper synchronizer, wider bus
        bus3 = 16'hBEEF;
        req3 = 1'b1;
        tick(N3);
        check("n3_early_valid", 32'(valid3), 32'd0);
        tick(1);
        check("n3_valid", 32'(valid3), 32'd1);
        check("n3_bus", 32'(sbus3), 32'hBEEF);
        check("n3_ack", 32'(ack3), 32'd1);
        req3 = 1'b0;
        tick(N3);
        check("n3_ack_hold", 32'(ack3), 32'd1);
        tick(1);
        check("n3_ack_fall", 32'(ack3), 32'd0);
        check("n3_cnt", 32'(cnt3), 32'd1);

        tick(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("pulse_total", 32'(seen_pulses), 32'(exp_pulses));
        check("n3_pulse_total", 32'(seen_pulses3), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
